div_seq_ctrl: RTL and testbench



---
 rtl/rv32im_pkg.sv | 26 ++
 rtl/div_seq_ctrl_if.sv | 24 ++
 rtl/div_iter_step.sv | 23 ++
 rtl/div_seq_ctrl.sv | 138 +++++++++++++
 tb/tb_div_seq_ctrl.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/rv32im_pkg.sv
// Shared RV32IM execute-stage definitions used by the divider sequencer.
package rv32im_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 6;

  localparam logic [1:0] DIV_OP_DIV  = 2'b00;
  localparam logic [1:0] DIV_OP_DIVU = 2'b01;
  localparam logic [1:0] DIV_OP_REM  = 2'b10;
  localparam logic [1:0] DIV_OP_REMU = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

  localparam logic [XLEN-1:0] DIV0_QUOT = 32'hFFFF_FFFF;
  localparam logic [XLEN-1:0] INT_MIN   = 32'h8000_0000;

  // Two's-complement negate.
  function automatic logic [XLEN-1:0] neg2c(input logic [XLEN-1:0] x);
    return ~x + XLEN'(1);
  endfunction

endpackage

// File: rtl/div_seq_ctrl_if.sv
// EX-stage divider handshake: pipeline side is master, sequencer is slave.
interface div_seq_ctrl_if;
  import rv32im_pkg::*;

  logic            StartE;
  logic [1:0]      DivOpE;
  logic [XLEN-1:0] SrcAE;
  logic [XLEN-1:0] SrcBE;
  logic            FlushE;
  logic            BusyE;
  logic            DoneE;
  logic [XLEN-1:0] DivResultE;

  modport master (
    output StartE, DivOpE, SrcAE, SrcBE, FlushE,
    input  BusyE, DoneE, DivResultE
  );

  modport slave (
    input  StartE, DivOpE, SrcAE, SrcBE, FlushE,
    output BusyE, DoneE, DivResultE
  );

endinterface

// File: rtl/div_iter_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract the divisor.
module div_iter_step
  import rv32im_pkg::*;
(
  input  logic [XLEN:0]   rem_in,
  input  logic            shift_bit,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN:0]   rem_next_c,
  output logic            quot_bit_c
);

  logic [XLEN+1:0] shifted;
  logic [XLEN+1:0] diff;

  // An extra guard bit makes the borrow of the trial subtraction visible.
  always_comb begin
    shifted    = {rem_in, shift_bit};
    diff       = shifted - {2'b00, divisor};
    quot_bit_c = ~diff[XLEN+1];
    rem_next_c = quot_bit_c ? diff[XLEN:0] : shifted[XLEN:0];
  end

endmodule

// File: rtl/div_seq_ctrl.sv
// Multi-cycle DIV/DIVU/REM/REMU sequencer for the EX stage; stalls the front end while running.
module div_seq_ctrl
  import rv32im_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  div_seq_ctrl_if.slave  dif
);

  div_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0]  dvd_q;
  logic [XLEN-1:0]  dvs_q;
  logic [XLEN:0]    rem_q;
  logic             is_rem_q;
  logic             qneg_q;
  logic             rneg_q;
  logic             done_q;
  logic [XLEN-1:0]  result_q;

  logic             start_ok;
  logic             signed_op;
  logic             is_rem;
  logic             sign_a;
  logic             sign_b;
  logic [XLEN-1:0]  abs_a;
  logic [XLEN-1:0]  abs_b;
  logic             div_zero;
  logic             ovf;
  logic [XLEN-1:0]  special_res;
  logic [XLEN:0]    step_rem;
  logic             step_q;
  logic [XLEN-1:0]  quot_fin;
  logic [XLEN-1:0]  rem_fin;
  logic [XLEN-1:0]  final_res;

  // Operand decode for a new instruction presented in IDLE.
  always_comb begin
    start_ok    = dif.StartE & ~dif.FlushE;
    signed_op   = (dif.DivOpE == DIV_OP_DIV) | (dif.DivOpE == DIV_OP_REM);
    is_rem      = (dif.DivOpE == DIV_OP_REM) | (dif.DivOpE == DIV_OP_REMU);
    sign_a      = signed_op & dif.SrcAE[XLEN-1];
    sign_b      = signed_op & dif.SrcBE[XLEN-1];
    abs_a       = sign_a ? neg2c(dif.SrcAE) : dif.SrcAE;
    abs_b       = sign_b ? neg2c(dif.SrcBE) : dif.SrcBE;
    div_zero    = (dif.SrcBE == '0);
    ovf         = signed_op & (dif.SrcAE == INT_MIN) & (dif.SrcBE == '1);
    special_res = '0;
    if (div_zero) begin
      special_res = is_rem ? dif.SrcAE : DIV0_QUOT;
    end else begin
      special_res = is_rem ? '0 : INT_MIN;
    end
  end

  div_iter_step u_step (
    .rem_in     (rem_q),
    .shift_bit  (dvd_q[XLEN-1]),
    .divisor    (dvs_q),
    .rem_next_c (step_rem),
    .quot_bit_c (step_q)
  );

  // The dividend register fills with quotient bits as it shifts out.
  always_comb begin
    quot_fin  = {dvd_q[XLEN-2:0], step_q};
    rem_fin   = step_rem[XLEN-1:0];
    final_res = '0;
    if (is_rem_q) begin
      final_res = rneg_q ? neg2c(rem_fin) : rem_fin;
    end else begin
      final_res = qneg_q ? neg2c(quot_fin) : quot_fin;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      is_rem_q <= 1'b0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (start_ok) begin
            if (div_zero || ovf) begin
              state    <= DONE;
              done_q   <= 1'b1;
              result_q <= special_res;
            end else begin
              state    <= RUN;
              cnt      <= '0;
              dvd_q    <= abs_a;
              dvs_q    <= abs_b;
              rem_q    <= '0;
              is_rem_q <= is_rem;
              qneg_q   <= sign_a ^ sign_b;
              rneg_q   <= sign_a;
            end
          end
        end
        RUN: begin
          if (dif.FlushE) begin
            state <= IDLE;
          end else begin
            dvd_q <= quot_fin;
            rem_q <= step_rem;
            cnt   <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(XLEN - 1)) begin
              state    <= DONE;
              done_q   <= 1'b1;
              result_q <= final_res;
            end
          end
        end
        DONE: begin
          // A StartE still high here belongs to the instruction now completing.
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign dif.BusyE      = ((state == IDLE) & start_ok) | ((state == RUN) & ~dif.FlushE);
  assign dif.DoneE      = done_q;
  assign dif.DivResultE = result_q;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Scoreboard bench for div_seq_ctrl: expected results queued at issue, checked on DoneE.
module tb_div_seq_ctrl;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;
  logic [31:0] exp_q[$];
  logic [31:0] last_res;

  div_seq_ctrl_if dif ();

  div_seq_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .dif   (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model built from the language's own signed/unsigned division.
  function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic sgn;
    sgn = ~op[0];
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : 32'h8000_0000;
    if (sgn) return op[1] ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
    return op[1] ? a % b : a / b;
  endfunction

  function automatic int exp_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return 1;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Issue one divide at the next falling edge and follow it to DoneE.
  task automatic run_div(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] expv);
    int lat;
    logic [31:0] e;
    lat = exp_lat(op, a, b);
    exp_q.push_back(expv);
    @(negedge clk);
    dif.StartE = 1'b1;
    dif.DivOpE = op;
    dif.SrcAE  = a;
    dif.SrcBE  = b;
    dif.FlushE = 1'b0;
    for (int t = 0; t <= lat; t++) begin
      #1;
      chk({tag, ".busy"}, 32'(dif.BusyE), 32'(t < lat));
      chk({tag, ".done"}, 32'(dif.DoneE), 32'(t == lat));
      if (t == lat) begin
        e = exp_q.pop_front();
        chk({tag, ".res"}, dif.DivResultE, e);
        last_res = e;
      end else begin
        @(negedge clk);
      end
    end
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    dif.StartE = 1'b0;
    dif.FlushE = 1'b0;
  endtask

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;
    n_vec      = 0;
    n_err      = 0;
    last_res   = 32'd0;
    reset      = 1'b0;
    dif.StartE = 1'b0;
    dif.DivOpE = 2'b00;
    dif.SrcAE  = 32'd0;
    dif.SrcBE  = 32'd0;
    dif.FlushE = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst.busy", 32'(dif.BusyE), 32'd0);
    chk("rst.done", 32'(dif.DoneE), 32'd0);
    chk("rst.res", dif.DivResultE, 32'd0);

    run_div("divu_100_7", 2'b01, 32'd100, 32'd7, 32'd14);
    run_div("remu_100_7", 2'b11, 32'd100, 32'd7, 32'd2);
    idle_cycle();
    run_div("div_m7_2", 2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    run_div("rem_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    idle_cycle();
    run_div("div_5_0", 2'b00, 32'd5, 32'd0, 32'hFFFF_FFFF);
    idle_cycle();
    run_div("rem_5_0", 2'b10, 32'd5, 32'd0, 32'd5);
    idle_cycle();
    run_div("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run_div("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
    idle_cycle();
    run_div("divu_big", 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
    idle_cycle();

    // Flush at t10 abandons the divide with no DoneE and the old result held.
    @(negedge clk);
    dif.StartE = 1'b1;
    dif.DivOpE = 2'b01;
    dif.SrcAE  = 32'd100;
    dif.SrcBE  = 32'd7;
    repeat (10) @(negedge clk);
    dif.FlushE = 1'b1;
    #1;
    chk("flush.busy_t10", 32'(dif.BusyE), 32'd0);
    @(negedge clk);
    dif.StartE = 1'b0;
    dif.FlushE = 1'b0;
    for (int i = 0; i < 30; i++) begin
      #1;
      chk("flush.busy", 32'(dif.BusyE), 32'd0);
      chk("flush.done", 32'(dif.DoneE), 32'd0);
      chk("flush.hold", dif.DivResultE, last_res);
      @(negedge clk);
    end
    run_div("divu_9_3", 2'b01, 32'd9, 32'd3, 32'd3);
    idle_cycle();

    // Asynchronous reset in the middle of a run.
    @(negedge clk);
    dif.StartE = 1'b1;
    dif.DivOpE = 2'b01;
    dif.SrcAE  = 32'd1000;
    dif.SrcBE  = 32'd7;
    repeat (15) @(negedge clk);
    dif.StartE = 1'b0;
    #1;
    chk("arst.busy_pre", 32'(dif.BusyE), 32'd1);
    #1;
    reset = 1'b0;
    #1;
    chk("arst.busy", 32'(dif.BusyE), 32'd0);
    chk("arst.done", 32'(dif.DoneE), 32'd0);
    chk("arst.res", dif.DivResultE, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 25; i++) begin
      #1;
      chk("arst.nodone", 32'(dif.DoneE), 32'd0);
      @(negedge clk);
    end

    // Randomised operands checked against the reference model.
    for (int i = 0; i < 8; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = (i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
      if (i == 3) ra = -32'sd1;
      run_div("rand", rop, ra, rb, ref_div(rop, ra, rb));
    end
    idle_cycle();

    chk("sb.empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global watchdog so the bench always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
